// File: rtl/ttt_pkg.sv
// Shared constants, result payload and move-check helper for the tic-tac-toe controller.
package ttt_pkg;

    localparam int unsigned N_CELLS = 9;
    localparam int unsigned N_LINES = 8;
    localparam int unsigned STATE_W = 3;

    // Controller states
    localparam logic [STATE_W-1:0] S_O_TURN  = 3'd0;
    localparam logic [STATE_W-1:0] S_CHECK_O = 3'd1;
    localparam logic [STATE_W-1:0] S_X_THINK = 3'd2;
    localparam logic [STATE_W-1:0] S_X_PLACE = 3'd3;
    localparam logic [STATE_W-1:0] S_CHECK_X = 3'd4;
    localparam logic [STATE_W-1:0] S_DONE    = 3'd5;

    // Winner codes
    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_X    = 2'b01;
    localparam logic [1:0] WINNER_O    = 2'b10;
    localparam logic [1:0] WINNER_DRAW = 2'b11;

    localparam logic [N_CELLS-1:0] BOARD_FULL = 9'h1FF;

    // Rows, columns, diagonals (bit i = cell i, row-major)
    localparam logic [N_LINES-1:0][N_CELLS-1:0] WIN_LINES = {
        9'h054, 9'h111, 9'h124, 9'h092, 9'h049, 9'h1C0, 9'h038, 9'h007
    };

    // Game result as seen by the display driver
    typedef struct packed {
        logic [1:0]         winner;
        logic [N_CELLS-1:0] line;
    } result_t;

    // AI move is usable only if exactly one cell is chosen and it is empty
    function automatic logic ai_move_ok(input logic [N_CELLS-1:0] mv,
                                        input logic [N_CELLS-1:0] occ);
        return $onehot(mv) && ((mv & occ) == '0);
    endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// Combinational three-in-a-row detector for one player's board.
module ttt_win_detect
    import ttt_pkg::*;
(
    input  logic [N_CELLS-1:0] i_board,
    output logic               o_win_c,
    output logic [N_CELLS-1:0] o_line_c
);

    // OR of every line fully covered by this player
    always_comb begin
        o_line_c = '0;
        for (int i = 0; i < int'(N_LINES); i++) begin
            if ((i_board & WIN_LINES[i]) == WIN_LINES[i]) begin
                o_line_c = o_line_c | WIN_LINES[i];
            end
        end
    end

    assign o_win_c = |o_line_c;

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: board registers, human move intake, AI think delay, win/draw detection.
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter int unsigned AI_DELAY = 4,
    parameter bit          X_FIRST  = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               new_game,
    input  logic               move_valid,
    input  logic [3:0]         move_idx,
    input  logic [N_CELLS-1:0] ai_move,
    output logic [N_CELLS-1:0] x_state,
    output logic [N_CELLS-1:0] o_state,
    output logic               o_turn,
    output logic               move_err,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic [N_CELLS-1:0] win_line,
    output logic               ai_fault
);

    localparam int unsigned        CNT_W    = (AI_DELAY > 1) ? $clog2(AI_DELAY) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(AI_DELAY - 1);
    localparam logic [STATE_W-1:0] S_INIT   = X_FIRST ? S_X_THINK : S_O_TURN;

    logic [STATE_W-1:0] r_state, w_state;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [N_CELLS-1:0] r_x, w_x;
    logic [N_CELLS-1:0] r_o, w_o;
    result_t            r_result, w_result;
    logic               r_ai_fault, w_ai_fault;
    logic               r_move_err, w_move_err;
    logic               r_o_turn, w_o_turn;
    logic               r_game_over, w_game_over;

    logic [N_CELLS-1:0] w_occ;
    logic [N_CELLS-1:0] w_idx_mask;
    logic               w_idx_ok;
    logic               w_x_win, w_o_win;
    logic [N_CELLS-1:0] w_x_line, w_o_line;

    ttt_win_detect u_win_x (
        .i_board  (r_x),
        .o_win_c  (w_x_win),
        .o_line_c (w_x_line)
    );

    ttt_win_detect u_win_o (
        .i_board  (r_o),
        .o_win_c  (w_o_win),
        .o_line_c (w_o_line)
    );

    assign w_occ      = r_x | r_o;
    assign w_idx_mask = (move_idx < 4'd9) ? (N_CELLS'(1) << move_idx) : '0;
    assign w_idx_ok   = (move_idx < 4'd9) && ((w_occ & w_idx_mask) == '0);

    // Next-state and next-register values; new_game overrides everything
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_x         = r_x;
        w_o         = r_o;
        w_result    = r_result;
        w_ai_fault  = r_ai_fault;
        w_move_err  = 1'b0;

        if (new_game) begin
            w_state    = S_INIT;
            w_cnt      = '0;
            w_x        = '0;
            w_o        = '0;
            w_result   = '{winner: WINNER_NONE, line: '0};
            w_ai_fault = 1'b0;
        end else begin
            case (r_state)
                S_O_TURN: begin
                    if (move_valid) begin
                        if (w_idx_ok) begin
                            w_o     = r_o | w_idx_mask;
                            w_state = S_CHECK_O;
                        end else begin
                            w_move_err = 1'b1;
                        end
                    end
                end
                S_CHECK_O: begin
                    if (w_o_win) begin
                        w_state  = S_DONE;
                        w_result = '{winner: WINNER_O, line: w_o_line};
                    end else if (w_occ == BOARD_FULL) begin
                        w_state  = S_DONE;
                        w_result = '{winner: WINNER_DRAW, line: '0};
                    end else begin
                        w_state = S_X_THINK;
                        w_cnt   = '0;
                    end
                end
                S_X_THINK: begin
                    if (r_cnt == CNT_LAST) begin
                        w_state = S_X_PLACE;
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
                S_X_PLACE: begin
                    if (ai_move_ok(ai_move, w_occ)) begin
                        w_x     = r_x | ai_move;
                        w_state = S_CHECK_X;
                    end else begin
                        w_ai_fault = 1'b1;
                        w_result   = '{winner: WINNER_NONE, line: '0};
                        w_state    = S_DONE;
                    end
                end
                S_CHECK_X: begin
                    if (w_x_win) begin
                        w_state  = S_DONE;
                        w_result = '{winner: WINNER_X, line: w_x_line};
                    end else if (w_occ == BOARD_FULL) begin
                        w_state  = S_DONE;
                        w_result = '{winner: WINNER_DRAW, line: '0};
                    end else begin
                        w_state = S_O_TURN;
                    end
                end
                S_DONE: begin
                    w_state = S_DONE;
                end
                default: begin
                    w_state = S_INIT;
                end
            endcase
        end

        w_o_turn    = (w_state == S_O_TURN);
        w_game_over = (w_state == S_DONE);
    end

    // State and board registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_INIT;
            r_cnt       <= '0;
            r_x         <= '0;
            r_o         <= '0;
            r_result    <= '{winner: WINNER_NONE, line: '0};
            r_ai_fault  <= 1'b0;
            r_move_err  <= 1'b0;
            r_o_turn    <= (S_INIT == S_O_TURN);
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_x         <= w_x;
            r_o         <= w_o;
            r_result    <= w_result;
            r_ai_fault  <= w_ai_fault;
            r_move_err  <= w_move_err;
            r_o_turn    <= w_o_turn;
            r_game_over <= w_game_over;
        end
    end

    assign x_state   = r_x;
    assign o_state   = r_o;
    assign o_turn    = r_o_turn;
    assign move_err  = r_move_err;
    assign game_over = r_game_over;
    assign winner    = r_result.winner;
    assign win_line  = r_result.line;
    assign ai_fault  = r_ai_fault;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Bench for ttt_game_ctrl: directed games plus random games against a cell-array game model.
module tb_ttt_game_ctrl;

    localparam int AI_DELAY = 4;
    localparam int AI_RAND  = 0;
    localparam int AI_EXPL  = 1;
    localparam int AI_JUNK  = 2;

    logic       clk;
    logic       rst_n;
    logic       new_game;
    logic       move_valid;
    logic [3:0] move_idx;
    logic [8:0] ai_move;
    logic [8:0] x_state;
    logic [8:0] o_state;
    logic       o_turn;
    logic       move_err;
    logic       game_over;
    logic [1:0] winner;
    logic [8:0] win_line;
    logic       ai_fault;

    ttt_game_ctrl #(.AI_DELAY(AI_DELAY), .X_FIRST(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .new_game   (new_game),
        .move_valid (move_valid),
        .move_idx   (move_idx),
        .ai_move    (ai_move),
        .x_state    (x_state),
        .o_state    (o_state),
        .o_turn     (o_turn),
        .move_err   (move_err),
        .game_over  (game_over),
        .winner     (winner),
        .win_line   (win_line),
        .ai_fault   (ai_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Game model: 0 empty, 1 X (AI), 2 O (human)
    int       board [9];
    int       lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                               '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    int       exp_winner;
    logic [8:0] exp_line;
    bit       exp_fault;
    bit       exp_done;

    function automatic logic [8:0] cells_of(input int p);
        logic [8:0] m = '0;
        for (int c = 0; c < 9; c++) if (board[c] == p) m[c] = 1'b1;
        return m;
    endfunction

    function automatic logic [8:0] line_of(input int p);
        logic [8:0] m = '0;
        for (int l = 0; l < 8; l++) begin
            if (board[lines[l][0]] == p && board[lines[l][1]] == p && board[lines[l][2]] == p) begin
                for (int k = 0; k < 3; k++) m[lines[l][k]] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic int n_filled();
        int n = 0;
        for (int c = 0; c < 9; c++) if (board[c] != 0) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 9; c++) board[c] = 0;
        exp_winner = 0;
        exp_line   = '0;
        exp_fault  = 1'b0;
        exp_done   = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input bit exp_oturn);
        chk({tag, ".x_state"},   32'(x_state),   32'(cells_of(1)));
        chk({tag, ".o_state"},   32'(o_state),   32'(cells_of(2)));
        chk({tag, ".winner"},    32'(winner),    32'(exp_winner));
        chk({tag, ".win_line"},  32'(win_line),  32'(exp_line));
        chk({tag, ".ai_fault"},  32'(ai_fault),  32'(exp_fault));
        chk({tag, ".game_over"}, 32'(game_over), 32'(exp_done));
        chk({tag, ".o_turn"},    32'(o_turn),    32'(exp_oturn));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One human move, then (if the game continues) the AI reply
    task automatic human_turn(input int idx, input int ai_sel, input logic [8:0] ai_val);
        logic [8:0] ai;
        int         empt[$];
        int         c;
        move_valid = 1'b1;
        move_idx   = 4'(idx);
        tick();
        move_valid = 1'b0;
        if (idx > 8 || board[idx] != 0) begin
            chk("reject.move_err", 32'(move_err), 32'd1);
            chk_state("reject", 1'b1);
            tick();
            chk("reject.pulse_end", 32'(move_err), 32'd0);
            return;
        end
        board[idx] = 2;
        chk("accept.move_err", 32'(move_err), 32'd0);
        chk_state("accept", 1'b0);
        tick();
        if (line_of(2) != '0) begin
            exp_winner = 2; exp_line = line_of(2); exp_done = 1'b1;
        end else if (n_filled() == 9) begin
            exp_winner = 3; exp_done = 1'b1;
        end
        chk_state("check_o", 1'b0);
        if (exp_done) return;

        case (ai_sel)
            AI_EXPL: ai = ai_val;
            AI_JUNK: ai = 9'($urandom);
            default: begin
                for (int k = 0; k < 9; k++) if (board[k] == 0) empt.push_back(k);
                ai = 9'(1) << empt[$urandom_range(0, empt.size() - 1)];
            end
        endcase

        // Think phase: ai_move and move_valid carry junk that must be ignored
        for (int i = 0; i < AI_DELAY; i++) begin
            ai_move    = 9'($urandom);
            move_valid = 1'($urandom_range(0, 1));
            move_idx   = 4'($urandom_range(0, 15));
            tick();
            chk("think.move_err", 32'(move_err), 32'd0);
        end
        move_valid = 1'b0;
        ai_move    = ai;
        chk("think.x_state", 32'(x_state), 32'(cells_of(1)));
        chk("think.game_over", 32'(game_over), 32'd0);
        tick();

        c = -1;
        for (int k = 0; k < 9; k++) if (ai[k]) c = k;
        if ($countones(ai) == 1 && board[c] == 0) begin
            board[c] = 1;
            chk_state("place", 1'b0);
            tick();
            if (line_of(1) != '0) begin
                exp_winner = 1; exp_line = line_of(1); exp_done = 1'b1;
            end else if (n_filled() == 9) begin
                exp_winner = 3; exp_done = 1'b1;
            end
            chk_state("check_x", !exp_done);
        end else begin
            exp_fault = 1'b1;
            exp_done  = 1'b1;
            chk_state("ai_fault", 1'b0);
        end
    endtask

    // Moves after the game has ended must change nothing
    task automatic move_after_done();
        move_valid = 1'b1;
        move_idx   = 4'($urandom_range(0, 9));
        tick();
        move_valid = 1'b0;
        chk("done.move_err", 32'(move_err), 32'd0);
        chk_state("done.hold", 1'b0);
        tick();
        chk_state("done.hold2", 1'b0);
    endtask

    task automatic start_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        model_reset();
        chk_state("new_game", 1'b1);
        chk("new_game.move_err", 32'(move_err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        new_game   = 1'b0;
        move_valid = 1'b0;
        move_idx   = '0;
        ai_move    = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_state("reset", 1'b1);
        chk("reset.move_err", 32'(move_err), 32'd0);
        rst_n = 1'b1;
        tick();
        chk_state("post_reset", 1'b1);

        // O on 4, AI held at cell 0 (x_state appears AI_DELAY+3 cycles after the move)
        human_turn(4, AI_EXPL, 9'h001);
        chk("first.o_state", 32'(o_state), 32'h010);
        chk("first.x_state", 32'(x_state), 32'h001);
        // Occupied cell and out-of-range indices are rejected
        human_turn(4, AI_EXPL, 9'h000);
        human_turn(0, AI_EXPL, 9'h000);
        human_turn(9, AI_EXPL, 9'h000);
        human_turn(15, AI_EXPL, 9'h000);

        // O wins on the top row
        start_new_game();
        human_turn(0, AI_EXPL, 9'h008);
        human_turn(1, AI_EXPL, 9'h010);
        human_turn(2, AI_EXPL, 9'h000);
        chk("o_row.winner", 32'(winner), 32'h2);
        chk("o_row.win_line", 32'(win_line), 32'h007);
        chk("o_row.game_over", 32'(game_over), 32'd1);
        move_after_done();

        // Non-one-hot AI move
        start_new_game();
        human_turn(0, AI_EXPL, 9'h003);
        chk("fault_2hot.ai_fault", 32'(ai_fault), 32'd1);
        chk("fault_2hot.winner", 32'(winner), 32'h0);
        move_after_done();
        start_new_game();
        chk("cleared.ai_fault", 32'(ai_fault), 32'd0);

        // AI picks the cell O just took
        human_turn(4, AI_EXPL, 9'h010);
        chk("fault_occ.ai_fault", 32'(ai_fault), 32'd1);
        chk("fault_occ.game_over", 32'(game_over), 32'd1);

        // new_game mid-think with a simultaneous move strobe
        start_new_game();
        move_valid = 1'b1;
        move_idx   = 4'd4;
        tick();
        move_valid = 1'b0;
        tick();
        tick();
        new_game   = 1'b1;
        move_valid = 1'b1;
        move_idx   = 4'd0;
        tick();
        new_game   = 1'b0;
        move_valid = 1'b0;
        model_reset();
        chk_state("ng_think", 1'b1);
        chk("ng_think.move_err", 32'(move_err), 32'd0);
        tick();
        chk("ng_think.move_err2", 32'(move_err), 32'd0);
        chk_state("ng_think2", 1'b1);

        // Full board, no line
        human_turn(0, AI_EXPL, 9'h002);
        human_turn(2, AI_EXPL, 9'h010);
        human_turn(3, AI_EXPL, 9'h020);
        human_turn(7, AI_EXPL, 9'h040);
        human_turn(8, AI_EXPL, 9'h000);
        chk("draw.winner", 32'(winner), 32'h3);
        chk("draw.win_line", 32'(win_line), 32'h000);
        move_after_done();

        // Final move completes two lines on a full board: win beats draw, lines OR together
        start_new_game();
        human_turn(1, AI_EXPL, 9'h001);
        human_turn(3, AI_EXPL, 9'h004);
        human_turn(5, AI_EXPL, 9'h040);
        human_turn(7, AI_EXPL, 9'h100);
        human_turn(4, AI_EXPL, 9'h000);
        chk("double.winner", 32'(winner), 32'h2);
        chk("double.win_line", 32'(win_line), 32'h0BA);

        // Random games
        for (int g = 0; g < 12; g++) begin
            start_new_game();
            for (int t = 0; t < 30 && !exp_done; t++) begin
                int idx;
                int sel;
                int empt[$];
                if ($urandom_range(0, 5) == 0) begin
                    idx = $urandom_range(0, 15);
                end else begin
                    for (int k = 0; k < 9; k++) if (board[k] == 0) empt.push_back(k);
                    idx = empt[$urandom_range(0, empt.size() - 1)];
                end
                sel = ($urandom_range(0, 9) == 0) ? AI_JUNK : AI_RAND;
                human_turn(idx, sel, 9'h000);
            end
            if (exp_done) move_after_done();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
